// File: rtl/tl_bus_router.sv
// TileLink-UL router: decodes one host request to one of N_DEV device ports,
// keeps a single transaction outstanding and returns a registered response.
module tl_bus_router #(
  parameter int                  N_DEV     = 4,
  parameter logic [31:0]         ADDR_MASK = 32'hF0000000,
  parameter logic [N_DEV*32-1:0] DEV_TAGS  = {32'hF0000000, 32'hE0000000,
                                              32'h80000000, 32'h00000000},
  parameter int                  TIMEOUT   = 16
) (
  input  logic               clock,
  input  logic               reset_in_n,
  input  logic               host_a_valid,
  output logic               host_a_ready,
  input  logic [2:0]         host_a_opcode,
  input  logic [31:0]        host_a_address,
  input  logic [3:0]         host_a_mask,
  input  logic [31:0]        host_a_data,
  output logic               host_d_valid,
  input  logic               host_d_ready,
  output logic [2:0]         host_d_opcode,
  output logic [31:0]        host_d_data,
  output logic               host_d_error,
  output logic [N_DEV-1:0]   dev_a_valid,
  input  logic [N_DEV-1:0]   dev_a_ready,
  output logic [2:0]         dev_a_opcode,
  output logic [31:0]        dev_a_address,
  output logic [3:0]         dev_a_mask,
  output logic [31:0]        dev_a_data,
  input  logic [N_DEV-1:0]   dev_d_valid,
  output logic [N_DEV-1:0]   dev_d_ready,
  input  logic [N_DEV*32-1:0] dev_d_data,
  input  logic [N_DEV-1:0]   dev_d_error,
  output logic [15:0]        err_count
);

  localparam int         SEL_W    = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  drop_sel_q, drop_sel_d;
  logic [7:0]        timer_q, timer_d;
  logic              drop_pending_q, drop_pending_d;
  logic              is_get_q, is_get_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [15:0]       err_count_q, err_count_d;

  logic [SEL_W-1:0]  hit;
  logic              any_hit;
  logic              hit_ready;
  logic              blocked;
  logic              sel_valid;
  logic              sel_err;
  logic [31:0]       sel_data;
  logic              drop_valid;
  logic              drain_en;
  logic              drop_fire;
  logic              err_inc;

  // Tags are listed device 0 first, so device i lives in the (N_DEV-1-i)th word.
  always_comb begin
    any_hit = 1'b0;
    hit     = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if ((host_a_address & ADDR_MASK) == DEV_TAGS[(N_DEV-1-i)*32 +: 32]) begin
        any_hit = 1'b1;
        hit     = SEL_W'(i);
      end
    end
  end

  always_comb begin
    hit_ready  = 1'b0;
    sel_valid  = 1'b0;
    sel_err    = 1'b0;
    sel_data   = '0;
    drop_valid = 1'b0;
    for (int i = 0; i < N_DEV; i++) begin
      if (hit == SEL_W'(i)) hit_ready = dev_a_ready[i];
      if (sel_q == SEL_W'(i)) begin
        sel_valid = dev_d_valid[i];
        sel_err   = dev_d_error[i];
        sel_data  = dev_d_data[i*32 +: 32];
      end
      if (drop_sel_q == SEL_W'(i)) drop_valid = dev_d_valid[i];
    end
  end

  // A device that timed out must return its late beat before it sees a new request.
  assign blocked   = drop_pending_q && any_hit && (hit == drop_sel_q);
  assign drain_en  = drop_pending_q && !((state_q == WAIT) && (sel_q == drop_sel_q));
  assign drop_fire = drain_en && drop_valid;

  always_comb begin
    for (int i = 0; i < N_DEV; i++) begin
      dev_a_valid[i] = (state_q == IDLE) && any_hit && !blocked &&
                       (hit == SEL_W'(i)) && host_a_valid;
      dev_d_ready[i] = ((state_q == WAIT) && (sel_q == SEL_W'(i))) ||
                       (drain_en && (drop_sel_q == SEL_W'(i)));
    end
  end

  assign dev_a_opcode  = host_a_opcode;
  assign dev_a_address = host_a_address;
  assign dev_a_mask    = host_a_mask;
  assign dev_a_data    = host_a_data;

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    timer_d        = timer_q;
    drop_pending_d = drop_pending_q;
    drop_sel_d     = drop_sel_q;
    is_get_d       = is_get_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    err_inc        = 1'b0;
    host_a_ready   = 1'b0;

    if (drop_fire) drop_pending_d = 1'b0;

    case (state_q)
      IDLE: begin
        host_a_ready = any_hit ? (hit_ready && !blocked) : 1'b1;
        if (host_a_valid && host_a_ready) begin
          is_get_d = (host_a_opcode == 3'd4);
          if (any_hit) begin
            sel_d   = hit;
            timer_d = '0;
            state_d = WAIT;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            err_inc    = 1'b1;
            state_d    = RESP;
          end
        end
      end
      WAIT: begin
        timer_d = timer_q + 8'd1;
        // A beat on the timeout cycle itself still counts as a normal response.
        if (sel_valid) begin
          rsp_data_d = (is_get_q && !sel_err) ? sel_data : 32'h0;
          rsp_err_d  = sel_err;
          state_d    = RESP;
        end else if (timer_q == TMO_LAST) begin
          rsp_data_d     = '0;
          rsp_err_d      = 1'b1;
          err_inc        = 1'b1;
          drop_pending_d = 1'b1;
          drop_sel_d     = sel_q;
          state_d        = RESP;
        end
      end
      RESP: begin
        if (host_d_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_count_d = (err_inc && (err_count_q != 16'hFFFF)) ? err_count_q + 16'd1 : err_count_q;
  end

  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      drop_sel_q     <= '0;
      timer_q        <= '0;
      drop_pending_q <= 1'b0;
      is_get_q       <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_data_q     <= '0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      drop_sel_q     <= drop_sel_d;
      timer_q        <= timer_d;
      drop_pending_q <= drop_pending_d;
      is_get_q       <= is_get_d;
      rsp_err_q      <= rsp_err_d;
      rsp_data_q     <= rsp_data_d;
      err_count_q    <= err_count_d;
    end
  end

  assign host_d_valid  = (state_q == RESP);
  assign host_d_opcode = {2'b00, is_get_q};
  assign host_d_data   = rsp_data_q;
  assign host_d_error  = rsp_err_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_tl_bus_router.sv
// Bench for tl_bus_router: cycle-stepped device models plus a transaction-level
// reference model that predicts each response, its latency and the error count.
module tb_tl_bus_router;
  localparam int N   = 4;
  localparam int TMO = 16;
  localparam logic [31:0] TAGS [N] = '{32'hF0000000, 32'hE0000000, 32'h80000000, 32'h00000000};

  logic            clock = 1'b0;
  logic            reset_in_n;
  logic            host_a_valid, host_a_ready;
  logic [2:0]      host_a_opcode;
  logic [31:0]     host_a_address, host_a_data;
  logic [3:0]      host_a_mask;
  logic            host_d_valid, host_d_ready, host_d_error;
  logic [2:0]      host_d_opcode;
  logic [31:0]     host_d_data;
  logic [N-1:0]    dev_a_valid, dev_a_ready, dev_d_valid, dev_d_ready, dev_d_error;
  logic [2:0]      dev_a_opcode;
  logic [31:0]     dev_a_address, dev_a_data;
  logic [3:0]      dev_a_mask;
  logic [N*32-1:0] dev_d_data;
  logic [15:0]     err_count;

  always #5 clock = ~clock;

  tl_bus_router #(.N_DEV(N), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_in_n(reset_in_n),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready), .host_a_opcode(host_a_opcode),
    .host_a_address(host_a_address), .host_a_mask(host_a_mask), .host_a_data(host_a_data),
    .host_d_valid(host_d_valid), .host_d_ready(host_d_ready), .host_d_opcode(host_d_opcode),
    .host_d_data(host_d_data), .host_d_error(host_d_error),
    .dev_a_valid(dev_a_valid), .dev_a_ready(dev_a_ready), .dev_a_opcode(dev_a_opcode),
    .dev_a_address(dev_a_address), .dev_a_mask(dev_a_mask), .dev_a_data(dev_a_data),
    .dev_d_valid(dev_d_valid), .dev_d_ready(dev_d_ready), .dev_d_data(dev_d_data),
    .dev_d_error(dev_d_error), .err_count(err_count)
  );

  int n_chk = 0;
  int n_bad = 0;
  int errcnt_m = 0;

  int          dev_lat [N];
  int          dev_cnt [N];
  bit          dev_busy[N];
  logic [31:0] dev_rd  [N];
  bit          dev_re  [N];
  bit          rnd_ardy = 1'b0;

  logic         s_afire, s_aready, s_dvalid, s_derr, s_dfire;
  logic [N-1:0] s_dav, s_ddr;
  logic [31:0]  s_ddata, s_addr, s_wdata;
  logic [2:0]   s_dop;
  logic [3:0]   s_mask;
  logic [15:0]  s_errc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & 32'hF0000000) == TAGS[i]) return i;
    return -1;
  endfunction

  // One clock: sample outputs mid-cycle, then advance the device models after the edge.
  task automatic tick();
    logic [N-1:0] afire, dfire;
    @(negedge clock);
    afire    = dev_a_valid & dev_a_ready;
    dfire    = dev_d_valid & dev_d_ready;
    s_afire  = host_a_valid && host_a_ready;
    s_aready = host_a_ready;
    s_dav    = dev_a_valid;
    s_ddr    = dev_d_ready;
    s_dvalid = host_d_valid;
    s_ddata  = host_d_data;
    s_derr   = host_d_error;
    s_dop    = host_d_opcode;
    s_errc   = err_count;
    s_mask   = dev_a_mask;
    s_addr   = dev_a_address;
    s_wdata  = dev_a_data;
    s_dfire  = host_d_valid && host_d_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (dfire[i]) begin
        dev_d_valid[i] = 1'b0;
        dev_busy[i]    = 1'b0;
      end
      if (afire[i]) begin
        dev_busy[i] = 1'b1;
        dev_cnt[i]  = dev_lat[i] - 1;
        dev_d_data[i*32 +: 32] = dev_rd[i];
        dev_d_error[i] = dev_re[i];
        if (dev_cnt[i] == 0) dev_d_valid[i] = 1'b1;
      end else if (dev_busy[i] && !dev_d_valid[i] && dev_cnt[i] > 0) begin
        dev_cnt[i]--;
        if (dev_cnt[i] == 0) dev_d_valid[i] = 1'b1;
      end
      dev_a_ready[i] = rnd_ardy ? ($urandom % 4 != 0) : 1'b1;
    end
  endtask

  function automatic bit any_busy();
    for (int i = 0; i < N; i++) if (dev_busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (any_busy() && k < 80) begin
      tick();
      k++;
    end
    check_eq("drain_done", any_busy(), 0);
  endtask

  // lat: cycles after device accept until its beat (0 = never answers).
  task automatic txn(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] wdata,
                     input logic [3:0] mask, input int lat, input logic [31:0] rdata,
                     input bit rerr, input int hold);
    int dev, exp_lat, n;
    bit acc, exp_err;
    logic [31:0] exp_data;
    logic [N-1:0] exp_dav;
    dev = decode(addr);
    exp_dav = '0;
    if (dev < 0) begin
      exp_lat = 1; exp_err = 1'b1; exp_data = 32'h0;
      if (errcnt_m < 65535) errcnt_m++;
    end else begin
      exp_dav[dev] = 1'b1;
      dev_lat[dev] = lat; dev_rd[dev] = rdata; dev_re[dev] = rerr;
      if (lat == 0 || lat > TMO) begin
        exp_lat = TMO + 1; exp_err = 1'b1; exp_data = 32'h0;
        if (errcnt_m < 65535) errcnt_m++;
      end else begin
        exp_lat = lat + 1; exp_err = rerr;
        exp_data = (op == 3'd4 && !rerr) ? rdata : 32'h0;
      end
    end
    host_a_valid = 1'b1; host_a_address = addr; host_a_opcode = op;
    host_a_data = wdata; host_a_mask = mask;
    acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      tick();
      acc = s_afire;
    end
    host_a_valid = 1'b0;
    check_eq("accept", acc, 1);
    if (!acc) return;
    check_eq("dev_a_valid", s_dav, exp_dav);
    if (dev >= 0) begin
      check_eq("dev_a_mask", s_mask, mask);
      check_eq("dev_a_addr", s_addr, addr);
      check_eq("dev_a_data", s_wdata, wdata);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_dvalid && n < 64);
    check_eq("rsp_latency", n, exp_lat);
    check_eq("rsp_data", s_ddata, exp_data);
    check_eq("rsp_error", s_derr, exp_err);
    check_eq("rsp_opcode", s_dop, (op == 3'd4) ? 3'd1 : 3'd0);
    check_eq("err_count", s_errc, errcnt_m);
    if (hold > 0) begin
      host_a_valid = 1'b1; host_a_address = 32'h00000100; host_a_opcode = 3'd4;
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq("hold_valid", s_dvalid, 1);
      check_eq("hold_data", s_ddata, exp_data);
      check_eq("hold_error", s_derr, exp_err);
      check_eq("hold_a_ready", s_aready, 0);
      check_eq("hold_dev_a", s_dav, 0);
    end
    host_a_valid = 1'b0;
    host_d_ready = 1'b1;
    tick();
    check_eq("rsp_fire", s_dfire, 1);
    host_d_ready = 1'b0;
    tick();
    check_eq("rsp_done", s_dvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dev, lat, hold, nib;
    logic [31:0] addr;
    logic [2:0] op;
    bit acc;
    reset_in_n = 1'b0;
    host_a_valid = 1'b0; host_a_opcode = '0; host_a_address = '0; host_a_mask = '0;
    host_a_data = '0; host_d_ready = 1'b0;
    dev_a_ready = '1; dev_d_valid = '0; dev_d_data = '0; dev_d_error = '0;
    for (int i = 0; i < N; i++) begin
      dev_lat[i] = 1; dev_cnt[i] = 0; dev_busy[i] = 1'b0; dev_rd[i] = '0; dev_re[i] = 1'b0;
    end
    tick(); tick();
    check_eq("rst_d_valid", s_dvalid, 0);
    check_eq("rst_d_data", s_ddata, 0);
    check_eq("rst_d_error", s_derr, 0);
    check_eq("rst_d_opcode", s_dop, 0);
    check_eq("rst_dev_a_valid", s_dav, 0);
    check_eq("rst_dev_d_ready", s_ddr, 0);
    check_eq("rst_err_count", s_errc, 0);
    reset_in_n = 1'b1;
    tick();

    txn(32'h80000010, 3'd4, 32'h0, 4'hF, 1, 32'hDEADBEEF, 1'b0, 0);
    txn(32'hF0000000, 3'd1, 32'hCAFE1234, 4'b0011, 2, 32'h12345678, 1'b0, 0);
    txn(32'h40000000, 3'd4, 32'h0, 4'hF, 1, 32'h0, 1'b0, 0);
    txn(32'h80000004, 3'd4, 32'h0, 4'hF, TMO, 32'hA5A5A5A5, 1'b0, 0);
    txn(32'h80000008, 3'd4, 32'h0, 4'hF, TMO + 1, 32'h5A5A5A5A, 1'b0, 0);
    wait_idle();
    txn(32'h80000040, 3'd4, 32'h0, 4'hF, 3, 32'h00000099, 1'b1, 0);
    txn(32'hF0000010, 3'd6, 32'h1, 4'hF, 1, 32'hBBBBBBBB, 1'b0, 0);
    txn(32'h80000030, 3'd0, 32'h55667788, 4'hF, 2, 32'h77777777, 1'b0, 5);

    // dev1 never answers: timeout, then stall for dev1 while dev3 is served.
    txn(32'hE0000004, 3'd4, 32'h0, 4'hF, 0, 32'h0, 1'b0, 0);
    host_a_valid = 1'b1; host_a_address = 32'hE0000010; host_a_opcode = 3'd4;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall_a_ready", s_aready, 0);
    end
    host_a_valid = 1'b0;
    txn(32'h00000040, 3'd4, 32'h0, 4'hF, 2, 32'h33330003, 1'b0, 0);
    dev_d_data[63:32] = 32'hBAD0BAD0;
    dev_d_valid[1] = 1'b1;
    tick();
    check_eq("late_drain_ready", s_ddr[1], 1);
    check_eq("late_not_fwd0", s_dvalid, 0);
    tick();
    check_eq("late_not_fwd1", s_dvalid, 0);
    check_eq("late_cleared", dev_busy[1], 0);
    txn(32'hE0000008, 3'd4, 32'h0, 4'hF, 3, 32'h11110001, 1'b0, 0);

    // Reset while waiting on dev2.
    dev_lat[2] = 5; dev_rd[2] = 32'hFEEDFACE; dev_re[2] = 1'b0;
    host_a_valid = 1'b1; host_a_address = 32'h80000020; host_a_opcode = 3'd4;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      tick();
      acc = s_afire;
    end
    host_a_valid = 1'b0;
    check_eq("rstw_accept", acc, 1);
    tick(); tick();
    reset_in_n = 1'b0;
    #1;
    check_eq("rstw_d_valid", host_d_valid, 0);
    check_eq("rstw_dev_d_ready", dev_d_ready, 0);
    check_eq("rstw_dev_a_valid", dev_a_valid, 0);
    check_eq("rstw_err_count", err_count, 0);
    check_eq("rstw_d_data", host_d_data, 0);
    check_eq("rstw_d_error", host_d_error, 0);
    errcnt_m = 0;
    tick();
    reset_in_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("rstw_no_fwd", s_dvalid, 0);
      check_eq("rstw_no_drain", s_ddr, 0);
      check_eq("rstw_errc", s_errc, 0);
    end
    dev_d_valid[2] = 1'b0; dev_busy[2] = 1'b0;
    tick();

    rnd_ardy = 1'b1;
    for (int t = 0; t < 60; t++) begin
      dev = $urandom % 5;
      if (dev < 4) begin
        addr = TAGS[dev] | ($urandom & 32'h0FFFFFFC);
      end else begin
        nib = $urandom_range(1, 12);
        if (nib > 7) nib = nib + 1;
        addr = (32'(nib) << 28) | ($urandom & 32'h0FFFFFFC);
      end
      op   = ($urandom % 2) ? 3'd4 : 3'($urandom % 8);
      lat  = $urandom_range(1, TMO + 6);
      hold = $urandom % 4;
      txn(addr, op, $urandom, 4'($urandom), lat, $urandom, ($urandom % 8) == 0, hold);
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/tl_bus_router.md
Name: tl_bus_router

Overview:
- Parametrised TileLink-UL router between the pinwheel core data port and N device ports (data RAM, regfile window, debug/serial registers, consoles).
- Replaces the fixed per-device response-priority chain in the top level with:
  - a generic address decoder,
  - a single-outstanding transaction tracker with a registered response,
  - error responses for unmapped addresses and for timed-out devices.

Parameters:
- N_DEV, 4, number of device ports (1..8).
- ADDR_MASK, 32'hF0000000, mask applied to the request address before tag compare.
- DEV_TAGS, {32'hF0000000, 32'hE0000000, 32'h80000000, 32'h00000000}, packed N_DEV x 32 tags; entry i is device i.
- TIMEOUT, 16, cycles in WAIT before an error response is returned (2..255).

Ports:
- clock  in  1  system clock
- reset_in_n  in  1  asynchronous active-low reset
- host_a_valid  in  1  request valid
- host_a_ready  out  1  request accepted this cycle
- host_a_opcode  in  3  TL opcode: 4=Get, 0=PutFullData, 1=PutPartialData
- host_a_address  in  32  byte address
- host_a_mask  in  4  byte mask
- host_a_data  in  32  write data
- host_d_valid  out  1  response valid
- host_d_ready  in  1  host accepts response
- host_d_opcode  out  3  1=AccessAckData, 0=AccessAck
- host_d_data  out  32  read data
- host_d_error  out  1  denied/timeout
- dev_a_valid  out  N_DEV  per-device request valid
- dev_a_ready  in  N_DEV  per-device request ready
- dev_a_opcode, dev_a_address, dev_a_mask, dev_a_data  out  3/32/4/32  broadcast copies of host request fields
- dev_d_valid  in  N_DEV  per-device response valid
- dev_d_ready  out  N_DEV  per-device response ready
- dev_d_data  in  N_DEV*32  per-device read data, device i at [32i+:32]
- dev_d_error  in  N_DEV  per-device error
- err_count  out  16  saturating count of decode errors and timeouts

Behaviour:
- Reset (async, reset_in_n=0):
  - state=IDLE; sel=0; timer=0; drop_pending=0; err_count=0.
  - host_d_valid=0, host_d_data=0, host_d_error=0, host_d_opcode=0.
  - All dev_a_valid=0 and dev_d_ready=0.
  - A reset mid-transaction abandons the transaction; no response is issued.
- Decode (combinational):
  - match[i] = ((host_a_address & ADDR_MASK) == DEV_TAGS[i]).
  - Lowest matching index wins. No match = decode error.
- States: IDLE, WAIT, RESP. Exactly one transaction is outstanding at a time.
- IDLE:
  - dev_a_valid[hit] = host_a_valid, combinational.
  - host_a_ready = 1 when there is no match; otherwise host_a_ready = dev_a_ready[hit].
  - host_a_ready is forced to 0 while drop_pending=1 and hit==drop_sel.
  - On request fire with a hit: sel<=hit, timer<=0, capture is_get = (opcode==4), go to WAIT.
  - On request fire with no hit: response regs <= error (data=0, error=1), err_count++, go to RESP. The error response is visible the next cycle.
- WAIT:
  - dev_d_ready[sel]=1; timer increments each cycle.
  - If dev_d_valid[sel]=1: capture dev_d_data[sel] and dev_d_error[sel], go to RESP. Response latency is 1 cycle after device d-fire.
  - Else if timer==TIMEOUT-1: error response, err_count++, drop_pending<=1, drop_sel<=sel, go to RESP.
  - A response arriving on the same cycle as the timeout wins; no timeout is recorded.
- RESP:
  - host_d_valid=1; outputs are held stable until host_d_ready=1.
  - host_d_opcode = is_get ? 1 : 0.
  - host_d_data is forced to 0 on error and for Put requests.
  - On fire, go to IDLE.
  - No new request is accepted in RESP. host_a_ready=0 in WAIT and RESP.
- Late-response drain:
  - While drop_pending=1: dev_d_ready[drop_sel]=1 in every state except WAIT with sel==drop_sel.
  - A dev_d_valid[drop_sel] beat is discarded and clears drop_pending.
- dev_d_ready of all other non-selected devices = 0.
- err_count saturates at 16'hFFFF.
- Unsupported opcodes are routed as Put: AccessAck, data 0.

Test Plan:
- Get at 0x80000010, dev2 ready, responds 1 cycle after accept with data 0xDEADBEEF:
  - dev_a_valid=4'b0100.
  - host_d_valid appears 1 cycle after dev d-fire with opcode=1, data=0xDEADBEEF, error=0.
- PutPartialData at 0xF0000000 with mask 4'b0011:
  - Routed to dev0 with mask 4'b0011 unchanged.
  - Response opcode=0, data=0.
- Get at 0x40000000 (unmapped):
  - host_a_ready=1, no dev_a_valid.
  - Next cycle: host_d_valid with error=1, data=0; err_count=1.
- Get to dev1 (0xE0000004), no response:
  - After 16 WAIT cycles: error response, err_count++.
  - A new request to dev1 stalls (host_a_ready=0) until dev1 returns its late beat, which is dropped.
  - A request to dev3 meanwhile proceeds normally.
- Host holds host_d_ready=0 for 5 cycles in RESP:
  - host_d_* remain stable; no new request is accepted; the transaction completes on the cycle host_d_ready rises.
- reset_in_n pulsed low while in WAIT:
  - All outputs return to 0 immediately (async).
  - After release, state=IDLE and err_count=0; the stale device response is not forwarded.
